load_controller: RTL and testbench

LOAD_CONTROLLER -- requirements
Module: load_controller

---
 rtl/load_controller_pkg.sv | 24 ++
 rtl/load_controller_addr_gen.sv | 15 +
 rtl/load_controller.sv | 143 ++++++++++++++
 tb/tb_load_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_controller_pkg.sv
// Shared definitions for the load controller: FSM state encoding and the
// instruction opcode set that the load path extends.
package load_controller_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 7;

    // Opcode set; op_load is the addition for this block
    localparam logic [OPCODE_W-1:0] op_none  = 7'b0000000;
    localparam logic [OPCODE_W-1:0] op_store = 7'b0000001;
    localparam logic [OPCODE_W-1:0] op_add   = 7'b0000010;
    localparam logic [OPCODE_W-1:0] op_sub   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] op_load  = 7'b0000100;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        RF_READ   = 3'd1,
        DM_REQ    = 3'd2,
        DM_WAIT   = 3'd3,
        WRITEBACK = 3'd4,
        DONE      = 3'd5
    } load_state_e;

endpackage

// File: rtl/load_controller_addr_gen.sv
// Effective-address adder for loads: base + offset, wrapping at 2^ADDRSIZE.
module load_addr_gen #(
    parameter int unsigned ADDRSIZE = 5
) (
    input  logic [ADDRSIZE-1:0] base,
    input  logic [ADDRSIZE-1:0] offset,
    output logic [ADDRSIZE-1:0] ea_c
);

    // Carry out of the top bit is dropped, giving the modular wrap
    always_comb begin
        ea_c = base + offset;
    end

endmodule

// File: rtl/load_controller.sv
// Load controller: reads a base register, forms base+offset, reads data
// memory and writes the word back into the register file.
// Optional feature: define LOAD_CTRL_ZERO_REG_EN to suppress writes to
// register 0 (the load still walks every state).
module load_controller
    import load_controller_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned ADDRSIZE = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] rs1,
    input  logic [ADDRSIZE-1:0] rd,
    input  logic [ADDRSIZE-1:0] offset,
    output logic [ADDRSIZE-1:0] rf_addr,
    input  logic [WORDSIZE-1:0] rf_data,
    output logic [ADDRSIZE-1:0] dm_addr,
    output logic                dm_read,
    input  logic [WORDSIZE-1:0] dm_data,
    output logic                rf_write_en,
    output logic [ADDRSIZE-1:0] rf_write_addr,
    output logic [WORDSIZE-1:0] rf_write_data,
    output logic                busy,
    output logic                done,
    output logic [WORDSIZE-1:0] loaded_value
);

    load_state_e         state_q, state_d;
    logic [ADDRSIZE-1:0] rd_q, rd_d;
    logic [ADDRSIZE-1:0] offset_q, offset_d;
    logic [ADDRSIZE-1:0] ea_c;
    logic                write_ok_c;

    logic [ADDRSIZE-1:0] rf_addr_d, dm_addr_d, rf_write_addr_d;
    logic [WORDSIZE-1:0] rf_write_data_d, loaded_value_d;
    logic                dm_read_d, rf_write_en_d, busy_d, done_d;

    // Only the low address bits of the base register take part in addressing
    logic unused_rf_data_hi;
    assign unused_rf_data_hi = ^rf_data[WORDSIZE-1:ADDRSIZE];

    load_addr_gen #(
        .ADDRSIZE(ADDRSIZE)
    ) u_addr_gen (
        .base   (rf_data[ADDRSIZE-1:0]),
        .offset (offset_q),
        .ea_c   (ea_c)
    );

`ifdef LOAD_CTRL_ZERO_REG_EN
    assign write_ok_c = (rd_q != '0);
`else
    assign write_ok_c = 1'b1;
`endif

    // Next state and next registered outputs, keyed on the state being entered
    always_comb begin
        state_d         = state_q;
        rd_d            = rd_q;
        offset_d        = offset_q;
        loaded_value_d  = loaded_value;
        rf_addr_d       = '0;
        dm_addr_d       = '0;
        dm_read_d       = 1'b0;
        rf_write_en_d   = 1'b0;
        rf_write_addr_d = '0;
        rf_write_data_d = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RF_READ;
                    rd_d      = rd;
                    offset_d  = offset;
                    rf_addr_d = rs1;
                end
            end
            RF_READ: begin
                state_d   = DM_REQ;
                dm_read_d = 1'b1;
                dm_addr_d = ea_c;
            end
            DM_REQ: begin
                state_d = DM_WAIT;
            end
            DM_WAIT: begin
                state_d        = WRITEBACK;
                loaded_value_d = dm_data;
                if (write_ok_c) begin
                    rf_write_en_d   = 1'b1;
                    rf_write_addr_d = rd_q;
                    rf_write_data_d = dm_data;
                end
            end
            WRITEBACK: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, latched operands and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_q          <= '0;
            offset_q      <= '0;
            rf_addr       <= '0;
            dm_addr       <= '0;
            dm_read       <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            loaded_value  <= '0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            offset_q      <= offset_d;
            rf_addr       <= rf_addr_d;
            dm_addr       <= dm_addr_d;
            dm_read       <= dm_read_d;
            rf_write_en   <= rf_write_en_d;
            rf_write_addr <= rf_write_addr_d;
            rf_write_data <= rf_write_data_d;
            busy          <= busy_d;
            done          <= done_d;
            loaded_value  <= loaded_value_d;
        end
    end

endmodule

// File: tb/tb_load_controller.sv
// Scoreboard bench for load_controller: random and directed loads against a
// memory-level reference model. Honors LOAD_CTRL_ZERO_REG_EN.
module tb_load_controller;

    localparam int unsigned WS   = 64;
    localparam int unsigned AS   = 5;
    localparam int unsigned NREG = 32;
`ifdef LOAD_CTRL_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AS-1:0] rs1, rd, offset, rf_addr, dm_addr, rf_write_addr;
    logic [WS-1:0] rf_data, dm_data, rf_write_data, loaded_value;
    logic          dm_read, rf_write_en, busy, done;

    logic [WS-1:0] rf_mem [NREG];
    logic [WS-1:0] ref_rf [NREG];
    logic [WS-1:0] mem    [NREG];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AS-1:0] rs1;
        logic [AS-1:0] ea;
        logic [AS-1:0] rd;
        logic [WS-1:0] data;
        bit            we;
        int            done_cyc;
    } exp_t;
    exp_t sbq[$];

    load_controller #(.WORDSIZE(WS), .ADDRSIZE(AS)) dut (
        .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rd(rd), .offset(offset),
        .rf_addr(rf_addr), .rf_data(rf_data), .dm_addr(dm_addr), .dm_read(dm_read),
        .dm_data(dm_data), .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .busy(busy), .done(done),
        .loaded_value(loaded_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: combinational register file, one-cycle-latency data memory
    assign rf_data = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (dm_read) dm_data <= mem[dm_addr];
        if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
    end

    function automatic void chk(string nm, logic [WS-1:0] got, logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    // Monitor: accumulate what one load does, compare against the queue at done
    int            acc_busy, acc_dm, acc_wr;
    logic [AS-1:0] acc_dm_addr, acc_wr_addr;
    logic [WS-1:0] acc_wr_data;
    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            chk("write_while_idle", WS'(rf_write_en), WS'(0));
            acc_busy = 0; acc_dm = 0; acc_wr = 0;
        end else begin
            if (acc_busy == 0 && sbq.size() > 0)
                chk("rf_addr_rs1", WS'(rf_addr), WS'(sbq[0].rs1));
            acc_busy++;
            if (dm_read) begin acc_dm++; acc_dm_addr = dm_addr; end
            if (rf_write_en) begin
                acc_wr++; acc_wr_addr = rf_write_addr; acc_wr_data = rf_write_data;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", WS'(done), WS'(0));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("dm_read_count", WS'(acc_dm), WS'(1));
                    chk("dm_addr", WS'(acc_dm_addr), WS'(e.ea));
                    chk("write_count", WS'(acc_wr), WS'(e.we ? 1 : 0));
                    if (e.we && acc_wr == 1) begin
                        chk("write_addr", WS'(acc_wr_addr), WS'(e.rd));
                        chk("write_data", acc_wr_data, e.data);
                    end
                    chk("loaded_value", loaded_value, e.data);
                    chk("done_cycle", WS'(cyc), WS'(e.done_cyc));
                    chk("busy_cycles", WS'(acc_busy), WS'(5));
                end
                acc_busy = 0; acc_dm = 0; acc_wr = 0;
            end
        end
    end

    task automatic set_reg(input int idx, input logic [WS-1:0] v);
        rf_mem[idx] = v;
        ref_rf[idx] = v;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        rs1 = AS'($urandom); rd = AS'($urandom); offset = AS'($urandom);
    endtask

    // Issue one load; inputs are scrambled every cycle after the start edge
    task automatic run_load(input logic [AS-1:0] r1, input logic [AS-1:0] rdv,
                            input logic [AS-1:0] off, input bit repulse);
        int   c0, n;
        exp_t e;
        @(negedge clk);
        rs1 = r1; rd = rdv; offset = off; start = 1'b1;
        c0 = cyc;
        e.rs1 = r1;
        e.ea = AS'((ref_rf[r1] + WS'(off)) % WS'(NREG));
        e.data = mem[e.ea];
        e.rd = rdv;
        e.we = !(ZERO_EN && rdv == 0);
        e.done_cyc = c0 + 5;
        if (e.we) ref_rf[rdv] = e.data;
        sbq.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = repulse && (cyc == c0 + 2);
            rand_inputs();
        end while (done !== 1'b1 && n < 12);
        start = 1'b0;
        if (done !== 1'b1) begin
            chk("load_timeout", WS'(done), WS'(1));
            apply_reset();
            sbq.delete();
        end
    endtask

    // Start a load and reset it while it waits for memory data
    task automatic abort_load();
        @(negedge clk);
        rand_inputs(); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", WS'(busy), WS'(0));
        chk("abort_done", WS'(done), WS'(0));
        chk("abort_write_en", WS'(rf_write_en), WS'(0));
        chk("abort_dm_read", WS'(dm_read), WS'(0));
        chk("abort_loaded_value", loaded_value, WS'(0));
        chk("abort_dm_addr", WS'(dm_addr), WS'(0));
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_write", WS'(rf_write_en), WS'(0));
            chk("abort_no_done", WS'(done), WS'(0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rs1 = '0; rd = '0; offset = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            set_reg(i, {$urandom, $urandom});
            mem[i] = {$urandom, $urandom};
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", WS'(busy), WS'(0));
        chk("reset_done", WS'(done), WS'(0));
        chk("reset_dm_read", WS'(dm_read), WS'(0));
        chk("reset_write_en", WS'(rf_write_en), WS'(0));
        chk("reset_loaded_value", loaded_value, WS'(0));
        chk("reset_addrs", WS'({rf_addr, dm_addr, rf_write_addr}), WS'(0));
        rst = 1'b0;

        // Basic load: base 4 + offset 2 -> mem[6] into r9
        set_reg(3, 64'h0000000000000004);
        mem[6] = 64'hDEADBEEFCAFEF00D;
        run_load(5'd3, 5'd9, 5'd2, 1'b0);
        chk("r9_after_load", rf_mem[9], 64'hDEADBEEFCAFEF00D);

        // Address wrap: 0x1E + 5 -> 3
        set_reg(1, 64'h000000000000001E);
        run_load(5'd1, 5'd10, 5'd5, 1'b0);
        // Upper base bits ignored: ...E1 -> 1
        set_reg(2, 64'hFFFFFFFFFFFFFFE1);
        run_load(5'd2, 5'd11, 5'd0, 1'b0);
        // Second start pulsed in DM_REQ must be ignored
        run_load(5'd4, 5'd12, 5'd7, 1'b1);
        // rd == rs1 is legal
        run_load(5'd13, 5'd13, 5'd1, 1'b0);
        // Writes to register 0
        run_load(5'd5, 5'd0, 5'd3, 1'b0);
        chk("r0_after_load", rf_mem[0], ref_rf[0]);

        // Reset while waiting for memory data
        abort_load();

        // Randomized loads, some back-to-back, some with a repeated start
        for (int k = 0; k < 40; k++) begin
            run_load(AS'($urandom), AS'($urandom), AS'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        for (int i = 0; i < int'(NREG); i++) chk("final_rf", rf_mem[i], ref_rf[i]);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", WS'(sbq.size()), WS'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
